load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage directly downstream of the instruction decoder. Consumes the decoded load/store controls (`mem_write`, `mem_width` = funct3, a read request derived from `result_src`), the ALU-computed address and rs2 store data. Issues one word-aligned, byte-enabled transaction per instruction on a valid/ready data-memory port. Returns aligned, sign- or zero-extended load data and stalls the core until the access completes.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles waited in `REQ` or `RESP` before aborting with `bus_err`. Must be ≥1.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_read` in 1: load instruction present; held until `done`.
- `req_write` in 1: store instruction present (decoder `mem_write`); held until `done`.
- `mem_width` in 3: funct3. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data (rs2).
- `busy` out 1: core stall request.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: formatted load data; valid only with `done` on a read.
- `misaligned` out 1: one-cycle pulse for a misaligned or illegal access.
- `bus_err` out 1: one-cycle pulse on timeout.
- `dmem_valid` out 1, `dmem_ready` in 1: request handshake.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 32: `{addr[31:2],2'b00}`.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_rvalid` in 1, `dmem_rdata` in 32: read response.

## Operation
- FSM states: `IDLE`, `REQ`, `RESP`.
- `IDLE` with a request:
  - If `req_read` and `req_write` are both high, the access is a store.
  - Legality check: halfword requires `addr[0]==0`; word requires `addr[1:0]==0`. Widths 011/110/111 are illegal. Stores with `mem_width[2]==1` are illegal.
  - Illegal access: `misaligned` pulses combinationally and `done` pulses in the same cycle. No memory access is made and the FSM stays in `IDLE`.
  - Legal access: latch addr, width, wdata and we, then go to `REQ`.
- `REQ`:
  - `dmem_valid`=1; all `dmem_*` outputs are stable from the latched values.
  - On `dmem_ready`, a write completes (`done` pulses, go to `IDLE`) and a read goes to `RESP`.
- `RESP`: on `dmem_rvalid`, `done` pulses, `rdata` is formatted from `dmem_rdata`, and the FSM goes to `IDLE`.
- Store lanes:
  - SB: `dmem_wdata`={4{wdata[7:0]}}, `dmem_be`=0001<<addr[1:0].
  - SH: {2{wdata[15:0]}}, be 0011 (addr[1]=0) or 1100.
  - SW: wdata, be 1111.
- Reads: `dmem_be`=1111, `dmem_we`=0.
- Load format: shift `dmem_rdata` right by 8·addr[1:0], then:
  - B/H: sign-extend bit 7/15.
  - BU/HU: zero-extend.
  - W: unmodified.
- Timeout counter:
  - Cleared on entry to `REQ` and on entry to `RESP`; increments each cycle spent waiting.
  - When it equals `TIMEOUT_CYCLES`, `bus_err` and `done` pulse, `rdata`=0, and the FSM goes to `IDLE`.
  - A late `dmem_rvalid` arriving in `IDLE` is ignored.
- `busy` = (`IDLE` & legal request) | (state≠`IDLE` & !`done`).

## Timing
- Reset: state `IDLE`, counter 0, latched fields 0. Every output is 0, including `busy`, which is forced 0 while `rst_n`=0.
- Reset mid-operation: the FSM returns to `IDLE` and `dmem_valid` drops asynchronously. A pending response is discarded.
- Request seen in cycle 0: `dmem_valid` rises in cycle 1.
- Store latency: `done` is in the same cycle `dmem_ready` is sampled high. Minimum is cycle 1, i.e. 1 stall cycle.
- Load latency: `dmem_rvalid` is legal no earlier than the cycle after acceptance. Minimum is `done` in cycle 2.
- `done`, `rdata`, `misaligned` and `bus_err` are combinational from state and inputs, so the core advances at the same edge. The next request is evaluated in the following cycle.
- `dmem_valid` never deasserts in `REQ` before `dmem_ready`, except on timeout or reset.

## Test plan
- SB, addr 0x1003, wdata 0x000000AB, `dmem_ready`=1 immediately -> cycle 1: `dmem_addr` 0x1000, be 1000, `dmem_wdata` 0xABABABAB, we=1, `done`=1. `busy`=1 in cycle 0 only.
- LB then LBU, addr 0x2002, `dmem_rdata` 0x12F45678 -> `rdata` 0xFFFFFFF4, then 0x000000F4. LH/LHU at 0x2002 -> 0x000012F4 for both.
- LH at addr 0x2001 -> `misaligned`=1 and `done`=1 in cycle 0, `dmem_valid` never rises. Repeat with `mem_width`=011 and with SB using `mem_width`=100 -> same response.
- SW at 0x3000 with `dmem_ready` low for 3 cycles -> `dmem_valid`, addr, be 1111 and wdata stable for 4 cycles. `done` in cycle 4, `busy` high in cycles 0-3.
- `TIMEOUT_CYCLES`=4, LW with `dmem_ready` accepted but `rvalid` never asserted -> `bus_err`+`done` after 4 cycles in `RESP`, `rdata`=0. A later stray `dmem_rvalid` produces no `done`.
- Assert `rst_n` low during `RESP` -> `dmem_valid`/`busy` drop immediately. After release, a fresh LW completes normally with correct data.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//
// Data-memory access stage that sits after the instruction decoder. It takes
// one load or store per instruction and turns it into a single word-aligned,
// byte-enabled transaction on a valid/ready data-memory port. Load data comes
// back aligned and sign- or zero-extended. The unit stalls the core with
// `busy` until the access completes, is rejected as illegal, or times out.
//
// Parameters
//   TIMEOUT_CYCLES : wait cycles allowed in REQ or RESP before the access is
//                    aborted with bus_err. Must be at least 1.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_read        : load present; held by the core until done
//   req_write       : store present; held by the core until done.
//                     If both requests are high, the access is a store.
//   mem_width       : funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr            : byte address from the ALU
//   wdata           : store data (rs2)
//   busy            : core stall request
//   done            : one-cycle completion pulse
//   rdata           : formatted load data, valid with done on a load
//   misaligned      : one-cycle pulse for a misaligned or illegal access
//   bus_err         : one-cycle pulse on timeout
//   dmem_valid      : request valid to data memory
//   dmem_ready      : data memory accepts the request
//   dmem_we         : write enable
//   dmem_addr       : word-aligned address
//   dmem_be         : byte enables
//   dmem_wdata      : lane-replicated store data
//   dmem_rvalid     : read response valid
//   dmem_rdata      : read response data
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [2:0]  mem_width,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        bus_err,
   output logic        dmem_valid,
   input  logic        dmem_ready,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [2:0]       width_q, width_d;
   logic             we_q, we_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        req_any;
   logic        width_ok;
   logic        align_ok;
   logic        legal;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] rdata_shifted;
   logic [31:0] rdata_fmt;
   logic        timeout;

   logic        busy_c;
   logic        done_c;
   logic        misaligned_c;
   logic        bus_err_c;
   logic [31:0] rdata_c;

   assign req_any = req_read | req_write;
   assign timeout = (cnt_q == CNT_MAX);

   // Legality of the incoming request. Byte accesses can sit at any address;
   // halfwords need an even address and words need a word-aligned address.
   // The unsigned widths only make sense for loads, so a store carrying
   // mem_width[2] is rejected as well.
   always_comb begin
      width_ok = 1'b0;
      align_ok = 1'b0;
      case (mem_width)
         3'b000, 3'b100: begin
            width_ok = 1'b1;
            align_ok = 1'b1;
         end
         3'b001, 3'b101: begin
            width_ok = 1'b1;
            align_ok = ~addr[0];
         end
         3'b010: begin
            width_ok = 1'b1;
            align_ok = (addr[1:0] == 2'b00);
         end
         default: begin
            width_ok = 1'b0;
            align_ok = 1'b0;
         end
      endcase
      legal = width_ok & align_ok & ~(req_write & mem_width[2]);
   end

   // Store lane steering. The data is replicated across all lanes so that the
   // memory only has to honour the byte enables. Loads always read the full
   // word and pick the bytes out on the way back.
   always_comb begin
      lane_be    = 4'b1111;
      lane_wdata = wdata;
      case (mem_width[1:0])
         2'b00: begin
            lane_be    = 4'b0001 << addr[1:0];
            lane_wdata = {4{wdata[7:0]}};
         end
         2'b01: begin
            lane_be    = addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{wdata[15:0]}};
         end
         default: begin
            lane_be    = 4'b1111;
            lane_wdata = wdata;
         end
      endcase
      if (!req_write) begin
         lane_be = 4'b1111;
      end
   end

   // Load formatting: bring the addressed byte/halfword down to bit 0, then
   // sign- or zero-extend it according to the latched width.
   always_comb begin
      rdata_shifted = dmem_rdata >> {addr_q[1:0], 3'b000};
      case (width_q)
         3'b000:  rdata_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         3'b001:  rdata_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         3'b100:  rdata_fmt = {24'h000000, rdata_shifted[7:0]};
         3'b101:  rdata_fmt = {16'h0000, rdata_shifted[15:0]};
         default: rdata_fmt = rdata_shifted;
      endcase
   end

   // Next-state and output logic. A completing response wins over a timeout
   // that expires in the same cycle. The counter restarts whenever REQ or
   // RESP is entered and counts every cycle spent waiting.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      width_d      = width_q;
      we_d         = we_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      busy_c       = 1'b0;
      done_c       = 1'b0;
      misaligned_c = 1'b0;
      bus_err_c    = 1'b0;
      rdata_c      = 32'h0;

      case (state_q)
         IDLE: begin
            if (req_any) begin
               if (!legal) begin
                  misaligned_c = 1'b1;
                  done_c       = 1'b1;
               end else begin
                  addr_d  = addr;
                  width_d = mem_width;
                  we_d    = req_write;
                  be_d    = lane_be;
                  wdata_d = lane_wdata;
                  cnt_d   = '0;
                  busy_c  = 1'b1;
                  state_d = REQ;
               end
            end
         end

         REQ: begin
            if (dmem_ready) begin
               if (we_q) begin
                  done_c  = 1'b1;
                  state_d = IDLE;
               end else begin
                  busy_c  = 1'b1;
                  cnt_d   = '0;
                  state_d = RESP;
               end
            end else if (timeout) begin
               bus_err_c = 1'b1;
               done_c    = 1'b1;
               state_d   = IDLE;
            end else begin
               busy_c = 1'b1;
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end

         RESP: begin
            if (dmem_rvalid) begin
               done_c  = 1'b1;
               rdata_c = rdata_fmt;
               state_d = IDLE;
            end else if (timeout) begin
               bus_err_c = 1'b1;
               done_c    = 1'b1;
               state_d   = IDLE;
            end else begin
               busy_c = 1'b1;
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched request fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= 32'h0;
         width_q <= 3'b000;
         we_q    <= 1'b0;
         be_q    <= 4'b0000;
         wdata_q <= 32'h0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         width_q <= width_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // The combinational pulses are gated with rst_n so that a request sitting
   // on the inputs during reset cannot raise busy, done or misaligned.
   assign busy       = busy_c & rst_n;
   assign done       = done_c & rst_n;
   assign misaligned = misaligned_c & rst_n;
   assign bus_err    = bus_err_c & rst_n;
   assign rdata      = rst_n ? rdata_c : 32'h0;

   assign dmem_valid = (state_q == REQ);
   assign dmem_we    = we_q;
   assign dmem_addr  = {addr_q[31:2], 2'b00};
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. A table of access records is
// replayed; each record drives the core-side request and a timed memory
// response, pushes its expectations into a scoreboard queue and pops them
// when done is observed. Hand-written sequences cover reset behaviour and a
// stray read response after a timeout.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int unsigned TMO = 4;

   logic        clk;
   logic        rst_n;
   logic        req_read;
   logic        req_write;
   logic [2:0]  mem_width;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        misaligned;
   logic        bus_err;
   logic        dmem_valid;
   logic        dmem_ready;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   load_store_unit #(
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_read   (req_read),
      .req_write  (req_write),
      .mem_width  (mem_width),
      .addr       (addr),
      .wdata      (wdata),
      .busy       (busy),
      .done       (done),
      .rdata      (rdata),
      .misaligned (misaligned),
      .bus_err    (bus_err),
      .dmem_valid (dmem_valid),
      .dmem_ready (dmem_ready),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_be    (dmem_be),
      .dmem_wdata (dmem_wdata),
      .dmem_rvalid(dmem_rvalid),
      .dmem_rdata (dmem_rdata)
   );

   // 10 time-unit clock; inputs change 1 unit after the rising edge and
   // outputs are sampled on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One access record. rdly is the number of cycles dmem_ready stays low
   // while dmem_valid is high (-1: never ready). vdly is the number of idle
   // cycles between acceptance+1 and dmem_rvalid (-1: never).
   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [2:0]  width;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      int          rdly;
      int          vdly;
      int          exp_done_cyc;
      int          exp_valid_cyc;
      logic        exp_mis;
      logic        exp_berr;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_dwdata;
   } vec_t;

   vec_t vecs[$];
   vec_t sb_q[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;

   function automatic vec_t mk(input string n, input logic rd, input logic wr,
                               input logic [2:0] w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] mr,
                               input int rdly, input int vdly, input int dc,
                               input int vc, input logic mis, input logic berr,
                               input logic [31:0] er, input logic [3:0] be,
                               input logic [31:0] ew);
      vec_t v;
      v.name = n;          v.rd = rd;             v.wr = wr;
      v.width = w;         v.addr = a;            v.wdata = wd;
      v.mrdata = mr;       v.rdly = rdly;         v.vdly = vdly;
      v.exp_done_cyc = dc; v.exp_valid_cyc = vc;  v.exp_mis = mis;
      v.exp_berr = berr;   v.exp_rdata = er;      v.exp_be = be;
      v.exp_dwdata = ew;
      return v;
   endfunction

   task automatic compareValue(input string what, input logic [31:0] act,
                               input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
      end
   endtask

   // Scoreboard pop: called in the cycle where done is seen.
   task automatic checkOutput();
      vec_t e;
      if (sb_q.size() == 0) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL scoreboard: done with no expected entry, got 1, expected 0");
         return;
      end
      e = sb_q.pop_front();
      compareValue({e.name, " misaligned"}, {31'h0, misaligned}, {31'h0, e.exp_mis});
      compareValue({e.name, " bus_err"}, {31'h0, bus_err}, {31'h0, e.exp_berr});
      compareValue({e.name, " busy at done"}, {31'h0, busy}, 32'h0);
      if (e.rd && !e.wr) begin
         compareValue({e.name, " rdata"}, rdata, e.exp_rdata);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      int cyc;
      int done_cyc;
      int valid_cyc;
      int busy_bad;
      int fld_bad;
      bit seen_done;
      cyc       = 0;
      done_cyc  = -1;
      valid_cyc = 0;
      busy_bad  = 0;
      fld_bad   = 0;
      seen_done = 1'b0;
      @(posedge clk);
      #1;
      req_read  = v.rd;
      req_write = v.wr;
      mem_width = v.width;
      addr      = v.addr;
      wdata     = v.wdata;
      sb_q.push_back(v);
      while (!seen_done && cyc < 20) begin
         if (cyc > 0) begin
            @(posedge clk);
            #1;
         end
         dmem_ready  = (v.rdly >= 0) && (cyc == v.rdly + 1);
         dmem_rvalid = (v.rdly >= 0) && (v.vdly >= 0) && (cyc == v.rdly + v.vdly + 2);
         dmem_rdata  = dmem_rvalid ? v.mrdata : 32'h0BAD_F00D;
         @(negedge clk);
         if (dmem_valid) begin
            valid_cyc++;
            if (dmem_addr !== (v.addr & 32'hFFFF_FFFC) || dmem_be !== v.exp_be ||
                dmem_we !== v.wr || (v.wr && dmem_wdata !== v.exp_dwdata)) begin
               fld_bad++;
            end
         end
         if (done) begin
            seen_done = 1'b1;
            done_cyc  = cyc;
            checkOutput();
         end else if (busy !== 1'b1) begin
            busy_bad++;
         end
         cyc++;
      end
      @(posedge clk);
      #1;
      req_read    = 1'b0;
      req_write   = 1'b0;
      dmem_ready  = 1'b0;
      dmem_rvalid = 1'b0;
      if (!seen_done) begin
         n_compared++;
         n_mismatched++;
         $display("[TB] FAIL %s: no done within 20 cycles, got 0, expected 1", v.name);
         void'(sb_q.pop_front());
      end
      compareValue({v.name, " done cycle"}, done_cyc, v.exp_done_cyc);
      compareValue({v.name, " valid cycles"}, valid_cyc, v.exp_valid_cyc);
      compareValue({v.name, " busy low before done"}, busy_bad, 32'h0);
      compareValue({v.name, " dmem fields unstable"}, fld_bad, 32'h0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n       = 1'b0;
      req_read    = 1'b0;
      req_write   = 1'b0;
      mem_width   = 3'b000;
      addr        = 32'h0;
      wdata       = 32'h0;
      dmem_ready  = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'h0;

      //        name                  rd wr width   addr          wdata         mrdata       rdly vdly dc vc mis berr exp_rdata     be       dwdata
      vecs.push_back(mk("SB 0x1003",   0, 1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0,  -1, 1, 1, 0, 0, 32'h0,         4'b1000, 32'hABAB_ABAB));
      vecs.push_back(mk("LB 0x2002",   1, 0, 3'b000, 32'h0000_2002, 32'h0,         32'h12F4_5678, 0,  0, 2, 1, 0, 0, 32'hFFFF_FFF4, 4'b1111, 32'h0));
      vecs.push_back(mk("LBU 0x2002",  1, 0, 3'b100, 32'h0000_2002, 32'h0,         32'h12F4_5678, 0,  0, 2, 1, 0, 0, 32'h0000_00F4, 4'b1111, 32'h0));
      vecs.push_back(mk("LH 0x2002",   1, 0, 3'b001, 32'h0000_2002, 32'h0,         32'h12F4_5678, 0,  0, 2, 1, 0, 0, 32'h0000_12F4, 4'b1111, 32'h0));
      vecs.push_back(mk("LHU 0x2002",  1, 0, 3'b101, 32'h0000_2002, 32'h0,         32'h12F4_5678, 0,  0, 2, 1, 0, 0, 32'h0000_12F4, 4'b1111, 32'h0));
      vecs.push_back(mk("LH 0x2001",   1, 0, 3'b001, 32'h0000_2001, 32'h0,         32'h0,        0,  0, 0, 0, 1, 0, 32'h0,         4'b0000, 32'h0));
      vecs.push_back(mk("width 011",   1, 0, 3'b011, 32'h0000_2000, 32'h0,         32'h0,        0,  0, 0, 0, 1, 0, 32'h0,         4'b0000, 32'h0));
      vecs.push_back(mk("SB width100", 0, 1, 3'b100, 32'h0000_2000, 32'h0000_0011, 32'h0,        0,  0, 0, 0, 1, 0, 32'h0,         4'b0000, 32'h0));
      vecs.push_back(mk("SW wait3",    0, 1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0,        3, -1, 4, 4, 0, 0, 32'h0,         4'b1111, 32'hDEAD_BEEF));
      vecs.push_back(mk("SH 0x4002",   0, 1, 3'b001, 32'h0000_4002, 32'h1234_ABCD, 32'h0,        1, -1, 2, 2, 0, 0, 32'h0,         4'b1100, 32'hABCD_ABCD));
      vecs.push_back(mk("SH 0x4000",   0, 1, 3'b001, 32'h0000_4000, 32'h1234_ABCD, 32'h0,        0, -1, 1, 1, 0, 0, 32'h0,         4'b0011, 32'hABCD_ABCD));
      vecs.push_back(mk("SB 0x4001",   0, 1, 3'b000, 32'h0000_4001, 32'hFFFF_FF5A, 32'h0,        0, -1, 1, 1, 0, 0, 32'h0,         4'b0010, 32'h5A5A_5A5A));
      vecs.push_back(mk("LW slow",     1, 0, 3'b010, 32'h0000_5000, 32'h0,         32'h89AB_CDEF, 1,  2, 5, 2, 0, 0, 32'h89AB_CDEF, 4'b1111, 32'h0));
      vecs.push_back(mk("LB 0x5001",   1, 0, 3'b000, 32'h0000_5001, 32'h0,         32'h0000_8000, 0,  0, 2, 1, 0, 0, 32'hFFFF_FF80, 4'b1111, 32'h0));
      vecs.push_back(mk("LB 0x5003",   1, 0, 3'b000, 32'h0000_5003, 32'h0,         32'h7F00_0000, 0,  0, 2, 1, 0, 0, 32'h0000_007F, 4'b1111, 32'h0));
      vecs.push_back(mk("LHU 0x5000",  1, 0, 3'b101, 32'h0000_5000, 32'h0,         32'hFFFF_8001, 0,  0, 2, 1, 0, 0, 32'h0000_8001, 4'b1111, 32'h0));
      vecs.push_back(mk("LH 0x5000",   1, 0, 3'b001, 32'h0000_5000, 32'h0,         32'hFFFF_8001, 0,  0, 2, 1, 0, 0, 32'hFFFF_8001, 4'b1111, 32'h0));
      vecs.push_back(mk("LW 0x5002",   1, 0, 3'b010, 32'h0000_5002, 32'h0,         32'h0,        0,  0, 0, 0, 1, 0, 32'h0,         4'b0000, 32'h0));
      vecs.push_back(mk("SW 0x5001",   0, 1, 3'b010, 32'h0000_5001, 32'h0,         32'h0,        0,  0, 0, 0, 1, 0, 32'h0,         4'b0000, 32'h0));
      vecs.push_back(mk("width 110",   1, 0, 3'b110, 32'h0000_5000, 32'h0,         32'h0,        0,  0, 0, 0, 1, 0, 32'h0,         4'b0000, 32'h0));
      vecs.push_back(mk("width 111",   1, 0, 3'b111, 32'h0000_5000, 32'h0,         32'h0,        0,  0, 0, 0, 1, 0, 32'h0,         4'b0000, 32'h0));
      vecs.push_back(mk("rd+wr SW",    1, 1, 3'b010, 32'h0000_6000, 32'h1122_3344, 32'h0,        0, -1, 1, 1, 0, 0, 32'h0,         4'b1111, 32'h1122_3344));
      vecs.push_back(mk("rd+wr SBU",   1, 1, 3'b100, 32'h0000_6000, 32'h0,         32'h0,        0,  0, 0, 0, 1, 0, 32'h0,         4'b0000, 32'h0));
      vecs.push_back(mk("SW REQ tmo",  0, 1, 3'b010, 32'h0000_6004, 32'h0000_0055, 32'h0,       -1, -1, 5, 5, 0, 1, 32'h0,         4'b1111, 32'h0000_0055));

      // Reset state, with requests sitting on the inputs.
      req_read  = 1'b1;
      mem_width = 3'b011;
      addr      = 32'h0000_0001;
      @(negedge clk);
      compareValue("reset busy (illegal req)", {31'h0, busy}, 32'h0);
      compareValue("reset misaligned", {31'h0, misaligned}, 32'h0);
      compareValue("reset done", {31'h0, done}, 32'h0);
      compareValue("reset bus_err", {31'h0, bus_err}, 32'h0);
      compareValue("reset rdata", rdata, 32'h0);
      compareValue("reset dmem_valid", {31'h0, dmem_valid}, 32'h0);
      compareValue("reset dmem_we", {31'h0, dmem_we}, 32'h0);
      compareValue("reset dmem_addr", dmem_addr, 32'h0);
      compareValue("reset dmem_be", {28'h0, dmem_be}, 32'h0);
      compareValue("reset dmem_wdata", dmem_wdata, 32'h0);
      mem_width = 3'b010;
      addr      = 32'h0000_0000;
      #1;
      compareValue("reset busy (legal req)", {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;
      req_read = 1'b0;
      rst_n    = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
      end

      // Read response timeout followed by a stray late response.
      applyStimulus(mk("LW RESP tmo", 1, 0, 3'b010, 32'h0000_6000, 32'h0, 32'h1357_9BDF,
                       0, -1, 6, 1, 0, 1, 32'h0, 4'b1111, 32'h0));
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1357_9BDF;
      @(negedge clk);
      compareValue("stray rvalid done", {31'h0, done}, 32'h0);
      compareValue("stray rvalid busy", {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;
      dmem_rvalid = 1'b0;

      // Reset while waiting in REQ: dmem_valid must drop at once.
      req_read  = 1'b1;
      mem_width = 3'b010;
      addr      = 32'h0000_7000;
      @(posedge clk);
      #1;
      @(negedge clk);
      compareValue("pre-reset REQ dmem_valid", {31'h0, dmem_valid}, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      compareValue("reset in REQ dmem_valid", {31'h0, dmem_valid}, 32'h0);
      compareValue("reset in REQ busy", {31'h0, busy}, 32'h0);
      req_read = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset while waiting in RESP: busy drops and the response is discarded.
      req_read  = 1'b1;
      mem_width = 3'b010;
      addr      = 32'h0000_7000;
      @(posedge clk);
      #1;
      dmem_ready = 1'b1;
      @(posedge clk);
      #1;
      dmem_ready = 1'b0;
      @(negedge clk);
      compareValue("pre-reset RESP busy", {31'h0, busy}, 32'h1);
      #1;
      rst_n       = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hCAFE_F00D;
      #1;
      compareValue("reset in RESP busy", {31'h0, busy}, 32'h0);
      compareValue("reset in RESP done", {31'h0, done}, 32'h0);
      compareValue("reset in RESP dmem_valid", {31'h0, dmem_valid}, 32'h0);
      req_read    = 1'b0;
      dmem_rvalid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      compareValue("after reset no done", {31'h0, done}, 32'h0);

      // A fresh load after the reset completes normally.
      applyStimulus(mk("LW after reset", 1, 0, 3'b010, 32'h0000_7000, 32'h0, 32'hCAFE_F00D,
                       0, 0, 2, 1, 0, 0, 32'hCAFE_F00D, 4'b1111, 32'h0));

      compareValue("scoreboard drained", sb_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
